// File: rtl/router_pkt_tx_if.sv
// Purpose : bundles the command, payload stream and router-side pins of router_pkt_tx.
// Latency : none (signal bundle only).
// Backpressure: pld_ready throttles the payload stream; busy from the router stalls the output.
//
// Signals:
//   start, dest_addr, pld_len     send command (sampled only while tx_ready=1)
//   pld_data, pld_valid/pld_ready payload byte stream into the packet buffer
//   busy                          router busy; a byte is consumed at an edge with busy=0
//   data_out, pkt_valid           to router data_in / pkt_valid
//   tx_ready, tx_done, cmd_err    status: idle, packet complete pulse, illegal command pulse
//   inj_err                       only with ROUTER_TX_ERR_INJ_EN: corrupt this packet's parity
// Modports: master = host/router environment, slave = router_pkt_tx.
interface router_pkt_tx_if #(
  parameter int DATA_W = 8
);
  logic              start;
  logic [1:0]        dest_addr;
  logic [5:0]        pld_len;
  logic [DATA_W-1:0] pld_data;
  logic              pld_valid;
  logic              pld_ready;
  logic              busy;
  logic [DATA_W-1:0] data_out;
  logic              pkt_valid;
  logic              tx_ready;
  logic              tx_done;
  logic              cmd_err;
`ifdef ROUTER_TX_ERR_INJ_EN
  logic              inj_err;

  modport master (
    output start, dest_addr, pld_len, pld_data, pld_valid, busy, inj_err,
    input  pld_ready, data_out, pkt_valid, tx_ready, tx_done, cmd_err
  );

  modport slave (
    input  start, dest_addr, pld_len, pld_data, pld_valid, busy, inj_err,
    output pld_ready, data_out, pkt_valid, tx_ready, tx_done, cmd_err
  );
`else
  modport master (
    output start, dest_addr, pld_len, pld_data, pld_valid, busy,
    input  pld_ready, data_out, pkt_valid, tx_ready, tx_done, cmd_err
  );

  modport slave (
    input  start, dest_addr, pld_len, pld_data, pld_valid, busy,
    output pld_ready, data_out, pkt_valid, tx_ready, tx_done, cmd_err
  );
`endif
endinterface

// File: rtl/router_pkt_tx.sv
// Purpose : store-and-forward packet source for a 1x3 router input port (header, payload, parity).
// Latency : header appears 1 cycle after the last payload beat; len+2 cycles on the wire, then IFG idle cycles.
// Backpressure: busy=1 freezes every output; pld_ready is high only while the packet is being loaded.
//
// Ports:
//   clock_i   single clock, all logic on posedge
//   resetn_i  asynchronous active-low reset; aborts any packet in flight
//   tx_if     router_pkt_tx_if.slave (command, payload stream, router pins, status)
// Optional feature: define ROUTER_TX_ERR_INJ_EN to add tx_if.inj_err, which flips bit 0
// of the transmitted parity byte for the packet it was latched with.
module router_pkt_tx #(
  parameter int DATA_W  = 8,
  parameter int MAX_LEN = 63,
  parameter int IFG     = 2
) (
  input logic          clock_i,
  input logic          resetn_i,
  router_pkt_tx_if.slave tx_if
);

  localparam int GAP_W = (IFG > 1) ? $clog2(IFG) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HEADER,
    S_PAYLOAD,
    S_PARITY,
    S_GAP
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        addr_q,  addr_d;
  logic [5:0]        len_q,   len_d;
  logic [5:0]        cnt_q,   cnt_d;
  logic [DATA_W-1:0] par_q,   par_d;
  logic [GAP_W-1:0]  gap_q,   gap_d;
  logic              done_q,  done_d;
  logic              err_q,   err_d;
  logic              mem_we;
  logic [DATA_W-1:0] par_out;
  logic [5:0]        last_idx;

  // Payload buffer; contents are don't-care after reset so it carries no reset.
  logic [DATA_W-1:0] mem_q [MAX_LEN];

  // Header byte layout: length in the upper bits, destination in the lower two.
  function automatic logic [DATA_W-1:0] mk_hdr(input logic [5:0] len, input logic [1:0] addr);
    return DATA_W'({len, addr});
  endfunction

  assign last_idx = len_q - 6'd1;

`ifdef ROUTER_TX_ERR_INJ_EN
  logic inj_q, inj_d;
  assign par_out = par_q ^ DATA_W'(inj_q);
`else
  assign par_out = par_q;
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      par_q   <= '0;
      gap_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef ROUTER_TX_ERR_INJ_EN
      inj_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      gap_q   <= gap_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef ROUTER_TX_ERR_INJ_EN
      inj_q   <= inj_d;
`endif
    end
  end

  always_ff @(posedge clock_i) begin
    if (mem_we) begin
      mem_q[cnt_q] <= tx_if.pld_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    gap_d   = gap_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    mem_we  = 1'b0;
`ifdef ROUTER_TX_ERR_INJ_EN
    inj_d   = inj_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (tx_if.start) begin
          if ((tx_if.dest_addr != 2'd3) && (tx_if.pld_len != 6'd0)) begin
            addr_d  = tx_if.dest_addr;
            len_d   = tx_if.pld_len;
            par_d   = mk_hdr(tx_if.pld_len, tx_if.dest_addr);
            cnt_d   = '0;
            state_d = S_LOAD;
`ifdef ROUTER_TX_ERR_INJ_EN
            inj_d   = tx_if.inj_err;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_LOAD: begin
        if (tx_if.pld_valid) begin
          mem_we = 1'b1;
          par_d  = par_q ^ tx_if.pld_data;
          if (cnt_q == last_idx) begin
            cnt_d   = '0;
            state_d = S_HEADER;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end

      S_HEADER: begin
        if (!tx_if.busy) begin
          state_d = S_PAYLOAD;
        end
      end

      S_PAYLOAD: begin
        if (!tx_if.busy) begin
          if (cnt_q == last_idx) begin
            cnt_d   = '0;
            state_d = S_PARITY;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end

      S_PARITY: begin
        if (!tx_if.busy) begin
          gap_d   = '0;
          state_d = S_GAP;
        end
      end

      S_GAP: begin
        // The gap is not stalled by busy: the router has nothing to consume here.
        if (gap_q == GAP_W'(IFG - 1)) begin
          gap_d   = '0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs: decoded from registered state only, so busy never reaches them
  // combinationally and they hold naturally while the FSM is stalled.
  // ---------------------------------------------------------------------------
  always_comb begin
    tx_if.pld_ready = (state_q == S_LOAD);
    tx_if.tx_ready  = (state_q == S_IDLE);
    tx_if.pkt_valid = (state_q == S_HEADER) || (state_q == S_PAYLOAD);
    tx_if.tx_done   = done_q;
    tx_if.cmd_err   = err_q;
    tx_if.data_out  = '0;
    case (state_q)
      S_HEADER:  tx_if.data_out = mk_hdr(len_q, addr_q);
      S_PAYLOAD: tx_if.data_out = mem_q[cnt_q];
      S_PARITY:  tx_if.data_out = par_out;
      default:   tx_if.data_out = '0;
    endcase
  end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Purpose : scoreboard bench for router_pkt_tx; expected output events are queued by the driver
//           and popped by an independent monitor on the falling clock edge.
// Latency : n/a.  Backpressure: a background process raises busy on selected bytes when enabled.
module tb_router_pkt_tx;

  localparam int DATA_W = 8;
  localparam int IFG    = 2;

  localparam int EV_BYTE = 0;
  localparam int EV_PAR  = 1;
  localparam int EV_DONE = 2;
  localparam int EV_ERR  = 3;

  typedef struct {
    int          kind;
    logic [31:0] val;
  } ev_t;

  logic clock  = 1'b0;
  logic resetn = 1'b1;
  always #5 clock = ~clock;

  router_pkt_tx_if #(.DATA_W(DATA_W)) ifc ();

  router_pkt_tx #(.DATA_W(DATA_W), .MAX_LEN(63), .IFG(IFG)) dut (
    .clock_i  (clock),
    .resetn_i (resetn),
    .tx_if    (ifc)
  );

  ev_t        exp_q[$];
  logic [7:0] pay[$];
  int         n_vec   = 0;
  int         n_miss  = 0;
  int         cyc     = 0;
  bit         stall_en = 1'b0;

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pop_cmp(input string name, input int kind, input logic [31:0] val);
    ev_t e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_miss++;
      $display("FAIL %s: unexpected event kind %0d value 0x%0h", name, kind, val);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val !== val) begin
        n_miss++;
        $display("FAIL %s: got kind %0d value 0x%0h, expected kind %0d value 0x%0h",
                 name, kind, val, e.kind, e.val);
      end
    end
  endtask

  task automatic push(input int kind, input logic [31:0] val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  initial begin
    logic       prev_vld;
    logic       prev_busy;
    logic [7:0] prev_dat;
    int         par_cyc;
    prev_vld  = 1'b0;
    prev_busy = 1'b0;
    prev_dat  = '0;
    par_cyc   = 0;
    forever begin
      @(negedge clock);
      if (!resetn) begin
        prev_vld  = 1'b0;
        prev_busy = 1'b0;
      end else begin
        if (prev_busy && prev_vld) begin
          chk("hold_vld", 32'(ifc.pkt_valid), 32'd1);
          chk("hold_dat", 32'(ifc.data_out), 32'(prev_dat));
        end
        if (ifc.pkt_valid && !ifc.busy)
          pop_cmp("byte", EV_BYTE, 32'(ifc.data_out));
        if (!ifc.pkt_valid && prev_vld) begin
          pop_cmp("parity", EV_PAR, 32'(ifc.data_out));
          par_cyc = cyc;
        end
        if (ifc.tx_done)
          pop_cmp("done_gap", EV_DONE, 32'(cyc - par_cyc));
        if (ifc.cmd_err)
          pop_cmp("cmd_err", EV_ERR, 32'(ifc.tx_ready));
        prev_vld  = ifc.pkt_valid;
        prev_busy = ifc.busy;
        prev_dat  = ifc.data_out;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Router busy model: when enabled, stalls the header and payload byte 2 for 3 cycles each.
  // ---------------------------------------------------------------------------
  initial begin
    int   idx;
    int   st;
    logic was_vld;
    idx     = 0;
    st      = 0;
    was_vld = 1'b0;
    ifc.busy = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      if (!resetn) begin
        idx      = 0;
        st       = 0;
        was_vld  = 1'b0;
        ifc.busy = 1'b0;
      end else begin
        if (was_vld && !ifc.busy) begin
          idx++;
          st = 0;
        end
        if (!ifc.pkt_valid) idx = 0;
        was_vld = ifc.pkt_valid;
        if (stall_en && ifc.pkt_valid && (idx == 0 || idx == 2) && st < 3) begin
          ifc.busy = 1'b1;
          st++;
        end else begin
          ifc.busy = 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic wait_ready();
    int k;
    k = 0;
    @(negedge clock);
    while (!ifc.tx_ready && k < 300) begin
      @(negedge clock);
      k++;
    end
    if (!ifc.tx_ready) chk("tx_ready_timeout", 32'(ifc.tx_ready), 32'd1);
  endtask

  // Issues a legal command for the payload in pay[] and loads it; returns once the
  // header should be on the wire. Expected events are queued before anything is driven.
  task automatic send(input logic [1:0] a, input logic [5:0] l, input bit toggle, input bit inj);
    logic [7:0] h;
    logic [7:0] par;
    int         k;
    h   = {l, a};
    par = h;
    push(EV_BYTE, 32'(h));
    for (int i = 0; i < int'(l); i++) begin
      push(EV_BYTE, 32'(pay[i]));
      par = par ^ pay[i];
    end
    push(EV_PAR, 32'(par ^ {7'b0, inj}));
    push(EV_DONE, 32'(IFG + 1));

    wait_ready();
    ifc.start     = 1'b1;
    ifc.dest_addr = a;
    ifc.pld_len   = l;
`ifdef ROUTER_TX_ERR_INJ_EN
    ifc.inj_err   = inj;
`endif
    @(posedge clock);
    #1;
    ifc.start = 1'b0;
`ifdef ROUTER_TX_ERR_INJ_EN
    ifc.inj_err = 1'b0;
`endif
    for (int i = 0; i < int'(l); i++) begin
      ifc.pld_valid = 1'b1;
      ifc.pld_data  = pay[i];
      k = 0;
      @(negedge clock);
      while (!ifc.pld_ready && k < 100) begin
        @(negedge clock);
        k++;
      end
      if (!ifc.pld_ready) chk("pld_ready_timeout", 32'(ifc.pld_ready), 32'd1);
      @(posedge clock);
      #1;
      ifc.pld_valid = 1'b0;
      if (i == int'(l) - 1) begin
        chk("hdr_latency", 32'({ifc.pkt_valid, ifc.data_out}), 32'({1'b1, h}));
      end else if (toggle) begin
        @(posedge clock);
        #1;
      end
    end
  endtask

  task automatic bad_cmd(input logic [1:0] a, input logic [5:0] l);
    push(EV_ERR, 32'd1);
    wait_ready();
    ifc.start     = 1'b1;
    ifc.dest_addr = a;
    ifc.pld_len   = l;
    @(posedge clock);
    #1;
    ifc.start = 1'b0;
    chk("bad_pld_ready", 32'(ifc.pld_ready), 32'd0);
    chk("bad_tx_ready", 32'(ifc.tx_ready), 32'd1);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 500) begin
      @(negedge clock);
      k++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss + 1);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int k;
    ifc.start     = 1'b0;
    ifc.dest_addr = '0;
    ifc.pld_len   = '0;
    ifc.pld_data  = '0;
    ifc.pld_valid = 1'b0;
`ifdef ROUTER_TX_ERR_INJ_EN
    ifc.inj_err   = 1'b0;
`endif

    // Reset state
    #3 resetn = 1'b0;
    #1;
    chk("rst_tx_ready",  32'(ifc.tx_ready),  32'd1);
    chk("rst_pld_ready", 32'(ifc.pld_ready), 32'd0);
    chk("rst_pkt_valid", 32'(ifc.pkt_valid), 32'd0);
    chk("rst_data_out",  32'(ifc.data_out),  32'd0);
    chk("rst_tx_done",   32'(ifc.tx_done),   32'd0);
    chk("rst_cmd_err",   32'(ifc.cmd_err),   32'd0);
    repeat (3) @(negedge clock);
    #2 resetn = 1'b1;

    // 1: addr=1 len=3, busy low throughout
    pay = '{8'hA1, 8'hB2, 8'hC3};
    send(2'd1, 6'd3, 1'b0, 1'b0);
    drain();

    // 2: busy stalls on the header and on payload byte 2
    pay = '{8'h11, 8'h22, 8'h33, 8'h44};
    stall_en = 1'b1;
    send(2'd0, 6'd4, 1'b0, 1'b0);
    drain();
    stall_en = 1'b0;

    // 3: illegal commands
    bad_cmd(2'd3, 6'd5);
    bad_cmd(2'd0, 6'd0);
    drain();
    chk("bad_end_pld_ready", 32'(ifc.pld_ready), 32'd0);

    // 4: maximum length with a gappy payload stream
    pay.delete();
    for (int i = 0; i < 63; i++) pay.push_back(8'(i * 7 + 3));
    send(2'd2, 6'd63, 1'b1, 1'b0);
    drain();

    // 5: reset during payload byte 10, then a clean packet
    pay.delete();
    for (int i = 0; i < 20; i++) pay.push_back(8'h40 + 8'(i));
    send(2'd1, 6'd20, 1'b0, 1'b0);
    k = 0;
    @(negedge clock);
    while (!(ifc.pkt_valid && ifc.data_out == pay[9]) && k < 100) begin
      @(negedge clock);
      k++;
    end
    chk("abort_reached_byte10", 32'(ifc.data_out), 32'(pay[9]));
    #2 resetn = 1'b0;
    exp_q.delete();
    #1;
    chk("abort_pkt_valid", 32'(ifc.pkt_valid), 32'd0);
    chk("abort_data_out",  32'(ifc.data_out),  32'd0);
    chk("abort_tx_ready",  32'(ifc.tx_ready),  32'd1);
    @(negedge clock);
    #2 resetn = 1'b1;
    pay = '{8'h5A, 8'hC3};
    send(2'd2, 6'd2, 1'b0, 1'b0);
    drain();

`ifdef ROUTER_TX_ERR_INJ_EN
    // 6: parity corruption on request
    pay = '{8'h00};
    send(2'd0, 6'd1, 1'b0, 1'b1);
    drain();
`endif

    repeat (4) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
